permute_ctrl: RTL
=================

PERMUTE_CTRL -- requirements
Module: permute_ctrl

Interface
REQ-001 Parameters (name, default, meaning); the block SHALL provide:
- NUM_ROUNDS, 24, Keccak-f rounds per permutation.
- ROUNDS_PER_CYCLE, 1, rounds computed per clock by the datapath.
- OUT_CNT_W, 16, width of the output-block request count.
REQ-002 NUM_ROUNDS not divisible by ROUNDS_PER_CYCLE SHALL be an elaboration error; STEPS = NUM_ROUNDS/ROUNDS_PER_CYCLE; RIDX_W = max(1, clog2(STEPS)).
REQ-003 Ports (name, direction, width, meaning); the block SHALL provide:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, reset, synchronous and active-low.
- input_buffer_ready, in, 1, stage-1 buffer holds a block.
- last_block_in_input_buffer, in, 1, buffered block is the message's last.
- output_buffer_available, in, 1, stage-3 buffer can accept a block.
- out_blocks, in, OUT_CNT_W, output blocks requested, valid with first block of a message.
- state_reset, out, 1, zero the Keccak state.
- copy_control_data, out, 1, latch per-message control data.
- absorb_enable, out, 1, XOR buffered block into state this cycle.
- round_en, out, 1, apply ROUNDS_PER_CYCLE rounds this cycle.
- round_idx, out, RIDX_W, current step index (round-constant select).
- input_buffer_ready_clr, out, 1, clear stage-1 ready flag.
- last_block_in_buffer_clr, out, 1, clear stage-1 last flag.
- output_buffer_we, out, 1, write state block to output buffer.
- output_buffer_available_clr, out, 1, clear stage-3 available flag.
- last_output_block, out, 1, block being written is the final one.
- busy, out, 1, message in progress.

Function
REQ-004 States SHALL be RESET, WAIT_IN, PERMUTE, DUMP; all outputs are Mealy/Moore combinational from state, internal registers and inputs, default 0.
REQ-005 RESET: assert state_reset, input_buffer_ready_clr, last_block_in_buffer_clr, output_buffer_available_clr; next WAIT_IN.
REQ-006 WAIT_IN with input_buffer_ready=0: hold, no outputs asserted.
REQ-007 WAIT_IN with input_buffer_ready=1: assert absorb_enable and input_buffer_ready_clr; last_block_in_buffer_clr = last_block_in_input_buffer; register last_flag = last_block_in_input_buffer; step counter := 0; next PERMUTE.
REQ-008 On the first block of a message (first_flag=1) the WAIT_IN accept cycle SHALL also assert copy_control_data, load blocks_left := out_blocks (0 loaded as 1), and clear first_flag.
REQ-009 PERMUTE: round_en=1, round_idx = step counter, counter increments each cycle; on step STEPS-1: last_flag=1 -> DUMP, else -> WAIT_IN.
REQ-010 Absorb of one block SHALL occupy exactly 1+STEPS cycles when input_buffer_ready is held high (25 cycles at defaults, 7 at ROUNDS_PER_CYCLE=4).
REQ-011 DUMP with output_buffer_available=0: hold, no write.
REQ-012 DUMP with output_buffer_available=1: assert output_buffer_we and output_buffer_available_clr; decrement blocks_left.
REQ-013 In that write cycle, if blocks_left=1: last_output_block=1, state_reset=1, first_flag:=1, last_flag:=0; next WAIT_IN. Otherwise: next PERMUTE with counter 0 (squeeze).
REQ-014 last_output_block SHALL equal (state==DUMP && blocks_left==1) in every cycle.
REQ-015 busy SHALL be 0 in RESET and in WAIT_IN with first_flag=1; 1 otherwise.
REQ-016 A new message SHALL be accepted in the cycle directly after the final write (no idle cycle) when input_buffer_ready=1; copy_control_data asserts in that cycle.
REQ-017 Inputs in unlisted state/condition combinations SHALL be ignored; illegal state encodings SHALL go to RESET.

Reset
REQ-018 rst=0 at a rising edge SHALL force state RESET, step counter 0, blocks_left 0, first_flag 1, last_flag 0, from any state including mid-permutation or mid-DUMP.
REQ-019 While in RESET (during rst=0 and the first cycle after release), RESET outputs per REQ-005 SHALL be driven; all other outputs are 0.

Verification
REQ-020 Single-block message, out_blocks=1, defaults -> absorb_enable at accept cycle T, round_en T+1..T+24 with round_idx 0..23, output_buffer_we at T+25, state_reset same cycle.
REQ-021 Three-block message, ready always high -> three absorb_enable pulses 25 cycles apart, copy_control_data only on the first, last_block_in_buffer_clr only on the third.
REQ-022 out_blocks=3, output_buffer_available low for 10 cycles after first write -> DUMP holds with no write; three writes total, last_output_block only on the third; out_blocks=0 yields exactly one write.
REQ-023 ROUNDS_PER_CYCLE=4 -> round_idx 0..5, block latency 7 cycles.
REQ-024 rst low for one cycle at PERMUTE step 10 -> next cycle RESET outputs, then WAIT_IN with busy=0; next message restarts at round_idx 0.
REQ-025 Back-to-back messages with ready high at final write -> copy_control_data in the cycle immediately after output_buffer_we.

Source files
------------

// File: rtl/permute_ctrl.sv
// Control FSM for a Keccak-f permutation core: sequences absorb, round
// iteration and squeeze/dump of output blocks for one message at a time.
module permute_ctrl #(
    parameter int unsigned NUM_ROUNDS       = 24,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned OUT_CNT_W        = 16,
    localparam int unsigned STEPS           = NUM_ROUNDS / ROUNDS_PER_CYCLE,
    localparam int unsigned RIDX_W          = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_buffer_ready,
    input  logic                 last_block_in_input_buffer,
    input  logic                 output_buffer_available,
    input  logic [OUT_CNT_W-1:0] out_blocks,
    output logic                 state_reset,
    output logic                 copy_control_data,
    output logic                 absorb_enable,
    output logic                 round_en,
    output logic [RIDX_W-1:0]    round_idx,
    output logic                 input_buffer_ready_clr,
    output logic                 last_block_in_buffer_clr,
    output logic                 output_buffer_we,
    output logic                 output_buffer_available_clr,
    output logic                 last_output_block,
    output logic                 busy
);

    // Round count must split evenly across the per-cycle datapath.
    if ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("permute_ctrl: NUM_ROUNDS must be a multiple of ROUNDS_PER_CYCLE");
    end

    localparam logic [RIDX_W-1:0]    LAST_STEP = RIDX_W'(STEPS - 1);
    localparam logic [OUT_CNT_W-1:0] ONE_BLK   = OUT_CNT_W'(1);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_WAIT_IN = 2'd1,
        S_PERMUTE = 2'd2,
        S_DUMP    = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [RIDX_W-1:0]      step, step_d;
    logic [OUT_CNT_W-1:0]   blocks_left, blocks_left_d;
    logic                   first_flag, first_d;
    logic                   last_flag, last_d;

    // State and message-tracking registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RESET;
            step        <= '0;
            blocks_left <= '0;
            first_flag  <= 1'b1;
            last_flag   <= 1'b0;
        end else begin
            state       <= state_d;
            step        <= step_d;
            blocks_left <= blocks_left_d;
            first_flag  <= first_d;
            last_flag   <= last_d;
        end
    end

    // Next-state logic and combinational control strobes.
    always_comb begin
        state_d                     = state;
        step_d                      = step;
        blocks_left_d               = blocks_left;
        first_d                     = first_flag;
        last_d                      = last_flag;
        state_reset                 = 1'b0;
        copy_control_data           = 1'b0;
        absorb_enable               = 1'b0;
        round_en                    = 1'b0;
        round_idx                   = '0;
        input_buffer_ready_clr      = 1'b0;
        last_block_in_buffer_clr    = 1'b0;
        output_buffer_we            = 1'b0;
        output_buffer_available_clr = 1'b0;
        last_output_block           = 1'b0;
        busy                        = 1'b1;

        case (state)
            S_RESET: begin
                busy                        = 1'b0;
                state_reset                 = 1'b1;
                input_buffer_ready_clr      = 1'b1;
                last_block_in_buffer_clr    = 1'b1;
                output_buffer_available_clr = 1'b1;
                state_d                     = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                busy = !first_flag;
                if (input_buffer_ready) begin
                    absorb_enable            = 1'b1;
                    input_buffer_ready_clr   = 1'b1;
                    last_block_in_buffer_clr = last_block_in_input_buffer;
                    last_d                   = last_block_in_input_buffer;
                    step_d                   = '0;
                    state_d                  = S_PERMUTE;
                    // First block carries the per-message control data.
                    if (first_flag) begin
                        copy_control_data = 1'b1;
                        blocks_left_d     = (out_blocks == '0) ? ONE_BLK : out_blocks;
                        first_d           = 1'b0;
                    end
                end
            end
            S_PERMUTE: begin
                round_en  = 1'b1;
                round_idx = step;
                if (step == LAST_STEP) begin
                    step_d  = '0;
                    state_d = last_flag ? S_DUMP : S_WAIT_IN;
                end else begin
                    step_d = step + RIDX_W'(1);
                end
            end
            S_DUMP: begin
                last_output_block = (blocks_left == ONE_BLK);
                if (output_buffer_available) begin
                    output_buffer_we            = 1'b1;
                    output_buffer_available_clr = 1'b1;
                    blocks_left_d               = blocks_left - ONE_BLK;
                    if (blocks_left == ONE_BLK) begin
                        state_reset = 1'b1;
                        first_d     = 1'b1;
                        last_d      = 1'b0;
                        state_d     = S_WAIT_IN;
                    end else begin
                        // Further output blocks need another squeeze permutation.
                        step_d  = '0;
                        state_d = S_PERMUTE;
                    end
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = S_RESET;
            end
        endcase
    end

endmodule
